// File: rtl/muldiv_seq_pkg.sv
// Shared definitions for the iterative multiply/divide sequencer.
//   MD_LENGTH  : operand width, one loop iteration per bit
//   md_op_e    : MULT / MULTU / DIV / DIVU encodings as issued by EXE
//   md_state_e : sequencer state encodings
package muldiv_seq_pkg;

    localparam int MD_LENGTH = 32;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        MD_IDLE = 2'b00,
        MD_RUN  = 2'b01,
        MD_DONE = 2'b10
    } md_state_e;

    function automatic logic op_is_div(input md_op_e op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic op_is_signed(input md_op_e op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration of the multiply/divide loop (purely combinational).
//   acc_i, mq_i : current {acc,mq} pair (product halves, or remainder/quotient)
//   operand_i   : multiplicand (multiply) or divisor (divide)
//   is_div_i    : 1 = restoring divide step, 0 = shift-add multiply step
//   acc_o, mq_o : pair after this iteration
module muldiv_step
    import muldiv_seq_pkg::*;
#(
    parameter int LENGTH = MD_LENGTH
) (
    input  logic [LENGTH-1:0] acc_i,
    input  logic [LENGTH-1:0] mq_i,
    input  logic [LENGTH-1:0] operand_i,
    input  logic              is_div_i,
    output logic [LENGTH-1:0] acc_o,
    output logic [LENGTH-1:0] mq_o
);

    logic [LENGTH:0]   sum;
    logic [LENGTH:0]   rem_s;
    logic [LENGTH-1:0] diff;
    logic              ge;

    always_comb begin
        // multiply: add keeps its carry so the right shift loses nothing
        sum   = {1'b0, acc_i} + (mq_i[0] ? {1'b0, operand_i} : '0);
        // divide: the shifted remainder needs LENGTH+1 bits for the trial compare
        rem_s = {acc_i, mq_i[LENGTH-1]};
        ge    = (rem_s >= {1'b0, operand_i});
        // when ge holds the true difference is below the divisor, so LENGTH bits suffice
        diff  = rem_s[LENGTH-1:0] - operand_i;

        if (is_div_i) begin
            acc_o = ge ? diff : rem_s[LENGTH-1:0];
            mq_o  = {mq_i[LENGTH-2:0], ge};
        end else begin
            acc_o = sum[LENGTH:1];
            mq_o  = {sum[0], mq_i[LENGTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning the HI/LO write port.
//   clk, rst (async, active-low)
//   start, op, src_a, src_b : request from EXE, sampled only in IDLE
//   flush                   : kill the operation in flight, no HI/LO write
//   busy, stall_req         : status / pipeline freeze to the hazard unit
//   wen_hilo, w_hi, w_lo    : one-cycle HI/LO write strobe and data
//
//   state | meaning
//   IDLE  | waiting for an accepted start
//   RUN   | one loop iteration per cycle, LENGTH cycles
//   DONE  | result on w_hi/w_lo, wen_hilo pulsed, back to IDLE
module muldiv_seq
    import muldiv_seq_pkg::*;
#(
    parameter int LENGTH = MD_LENGTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [LENGTH-1:0] src_a,
    input  logic [LENGTH-1:0] src_b,
    input  logic              flush,
    output logic              busy,
    output logic              stall_req,
    output logic              wen_hilo,
    output logic [LENGTH-1:0] w_hi,
    output logic [LENGTH-1:0] w_lo
);

    localparam int CNT_W = $clog2(LENGTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LENGTH - 1);

    md_state_e         state_q;
    md_op_e            op_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [LENGTH-1:0] acc_q, mq_q, operand_q;
    logic              neg_res_q, neg_rem_q;
    logic [LENGTH-1:0] w_hi_q, w_lo_q;

    md_op_e            op_in;
    logic              in_div, in_signed;
    logic [LENGTH-1:0] abs_a, abs_b;
    logic [LENGTH-1:0] acc_next, mq_next;
    logic [2*LENGTH-1:0] prod, prod_fix;
    logic [LENGTH-1:0] res_hi, res_lo;

    assign op_in     = md_op_e'(op);
    assign in_div    = op_is_div(op_in);
    assign in_signed = op_is_signed(op_in);
    assign abs_a     = (in_signed && src_a[LENGTH-1]) ? -src_a : src_a;
    assign abs_b     = (in_signed && src_b[LENGTH-1]) ? -src_b : src_b;

    muldiv_step #(.LENGTH(LENGTH)) u_step (
        .acc_i     (acc_q),
        .mq_i      (mq_q),
        .operand_i (operand_q),
        .is_div_i  (op_is_div(op_q)),
        .acc_o     (acc_next),
        .mq_o      (mq_next)
    );

    // Sign fix applied to the final iteration's output so DONE already holds the result.
    always_comb begin
        prod     = {acc_next, mq_next};
        prod_fix = neg_res_q ? -prod : prod;
        if (op_is_div(op_q)) begin
            res_lo = neg_res_q ? -mq_next : mq_next;
            res_hi = neg_rem_q ? -acc_next : acc_next;
        end else begin
            res_hi = prod_fix[2*LENGTH-1:LENGTH];
            res_lo = prod_fix[LENGTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= MD_IDLE;
            op_q      <= MD_MULT;
            cnt_q     <= '0;
            acc_q     <= '0;
            mq_q      <= '0;
            operand_q <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            w_hi_q    <= '0;
            w_lo_q    <= '0;
        end else begin
            case (state_q)
                MD_IDLE: begin
                    if (start && !flush) begin
                        op_q  <= op_in;
                        cnt_q <= '0;
                        if (in_div && (src_b == '0)) begin
                            w_lo_q  <= '1;
                            w_hi_q  <= src_a;
                            state_q <= MD_DONE;
                        end else begin
                            acc_q     <= '0;
                            mq_q      <= in_div ? abs_a : abs_b;
                            operand_q <= in_div ? abs_b : abs_a;
                            neg_res_q <= in_signed && (src_a[LENGTH-1] ^ src_b[LENGTH-1]);
                            neg_rem_q <= in_signed && src_a[LENGTH-1];
                            state_q   <= MD_RUN;
                        end
                    end
                end
                MD_RUN: begin
                    if (flush) begin
                        state_q <= MD_IDLE;
                    end else begin
                        acc_q <= acc_next;
                        mq_q  <= mq_next;
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_LAST) begin
                            w_hi_q  <= res_hi;
                            w_lo_q  <= res_lo;
                            state_q <= MD_DONE;
                        end
                    end
                end
                // A start seen here belongs to the instruction behind; only IDLE may accept it.
                MD_DONE: state_q <= MD_IDLE;
                default: state_q <= MD_IDLE;
            endcase
        end
    end

    assign busy      = (state_q != MD_IDLE);
    assign stall_req = !flush && (((state_q == MD_IDLE) && start) || (state_q == MD_RUN));
    assign wen_hilo  = (state_q == MD_DONE) && !flush;
    assign w_hi      = w_hi_q;
    assign w_lo      = w_lo_q;

endmodule
